mem: RTL and testbench
======================

# mem

Memory-access stage of the 5-stage MIPS pipeline. Sits between the EX stage and the MEM/WB register. It takes one instruction per handshake from EX and drives the data-SRAM-like bus for loads and stores. It aligns and extends load data, then registers the final write-back triple (destination, write enable, data) for the WB stage. While a memory transaction is outstanding it stalls upstream.

## Interface
- Parameters: none; 32-bit datapath and 5-bit register index are fixed.
- clk  in  1  pipeline clock
- rst  in  1  synchronous, active-high reset
- ex_valid  in  1  EX presents an instruction this cycle
- ex_wd  in  5  destination register
- ex_reg  in  1  register write enable
- ex_wdata  in  32  ALU result (used when ex_memop is none)
- ex_memop  in  4  0 none, 1 LB, 2 LBU, 3 LH, 4 LHU, 5 LW, 6 SB, 7 SH, 8 SW; 9–15 treated as none
- ex_addr  in  32  effective address
- ex_sdata  in  32  store source register value
- mem_ready  out  1  combinational; 1 only in IDLE; EX transfer happens when ex_valid & mem_ready
- data_req  out  1  bus request
- data_wr  out  1  1 store, 0 load
- data_size  out  2  0 byte, 1 half, 2 word
- data_addr  out  32  full byte address
- data_wdata  out  32  lane-replicated store data
- data_addr_ok  in  1  request accepted
- data_data_ok  in  1  read data valid / write done
- data_rdata  in  32  read word (little-endian lanes)
- mem_valid  out  1  one-cycle pulse per completed instruction
- mem_wd  out  5  destination to WB
- mem_reg  out  1  write enable to WB
- mem_wdata  out  32  write-back data to WB
- mem_excp  out  1  address-error flag, valid with mem_valid

## Operation
- FSM states: IDLE, REQ, WAIT. Reset state is IDLE.
- IDLE, transfer with a non-memory op: next edge registers mem_valid=1, mem_wd=ex_wd, mem_reg=ex_reg, mem_wdata=ex_wdata. Stay in IDLE.
- IDLE, transfer with a memory op: latch wd, reg, op, addr and sdata.
  - Misaligned access → no bus request; next edge emits mem_valid=1, mem_excp=1, mem_reg=0, mem_wdata=addr.
    - Halfword ops are misaligned when addr[0]=1.
    - Word ops are misaligned when addr[1:0]≠0.
  - Otherwise → go to REQ.
- REQ: data_req=1 with stable wr, size, addr and wdata.
  - On addr_ok → WAIT.
  - If addr_ok and data_ok arrive in the same cycle → complete directly, as in WAIT.
- WAIT: data_req=0. On data_ok → register outputs and go to IDLE.
- Load result, with lane a=addr[1:0] and halfword select addr[1]:
  - LB / LBU: byte a, sign- or zero-extended.
  - LH / LHU: half addr[1], sign- or zero-extended.
  - LW: full word.
- Store completion: mem_wdata=0, mem_reg=latched ex_reg (0 from decode).
- Store data on the bus:
  - SB: {4{sdata[7:0]}}.
  - SH: {2{sdata[15:0]}}.
  - SW: sdata.
- Bus outputs are 0 whenever data_req=0.
- Whenever mem_valid=0, mem_reg=0, mem_wd=0 and mem_excp=0; mem_wdata holds its last value.
- data_ok seen in IDLE or REQ without a prior addr_ok is ignored.

## Timing
- Reset values: all outputs 0 except mem_ready=1. rst in REQ or WAIT aborts to IDLE; a late data_ok is then ignored.
- Non-memory op: result appears 1 cycle after transfer; throughput 1 per cycle.
- Memory op, minimum: transfer at cycle 0, request at cycle 1 with addr_ok&data_ok, mem_valid at cycle 2. Next transfer is possible at cycle 2 (mem_ready=1 again).
- Each extra cycle of addr_ok or data_ok latency adds one cycle; mem_ready stays 0 throughout.
- mem_valid is high for exactly one cycle per instruction; it is never high on two cycles for the same instruction.

## Test plan
- Back-to-back ALU ops: wd=3/wdata=0x11, then wd=4/wdata=0x22 → mem_valid on 2 consecutive cycles with those values; mem_ready stays 1.
- LB at addr 0x1003, rdata=0x80FF_1234, addr_ok and data_ok in the same cycle → data_size=0, mem_wdata=0xFFFF_FF80, mem_valid 2 cycles after transfer.
- LHU at addr 0x2002, addr_ok after 2 waits, data_ok after 3 more, rdata=0xBEEF_0000 → mem_ready low for 6 cycles, mem_wdata=0x0000_BEEF.
- SB sdata=0x1234_56AB at 0x0 → data_wr=1, data_wdata=0xABAB_ABAB; on completion mem_reg=0.
- LW at 0x0000_0006 → no data_req; mem_excp=1, mem_reg=0, mem_wdata=0x6 one cycle later.
- rst asserted in WAIT, then a stray data_ok → all outputs 0, state IDLE, no mem_valid pulse.

Source files
------------

// File: rtl/mem.sv
// -----------------------------------------------------------------------------
// mem -- memory-access stage of the 5-stage MIPS pipeline.
//
// Accepts one instruction per handshake from EX (ex_valid & mem_ready). ALU
// results pass straight through to the MEM/WB register. Loads and stores are
// issued on an SRAM-like bus with separate address and data acknowledges. Load
// data is aligned and extended here. Misaligned halfword and word accesses never
// reach the bus; they complete as an address-error result instead.
//
// Ports
//   clk, rst          pipeline clock, synchronous active-high reset
//   ex_valid          EX presents an instruction
//   ex_wd/ex_reg      destination register and its write enable
//   ex_wdata          ALU result, used by non-memory ops
//   ex_memop          0 none, 1 LB, 2 LBU, 3 LH, 4 LHU, 5 LW, 6 SB, 7 SH, 8 SW
//                     (9..15 behave as none)
//   ex_addr/ex_sdata  effective address and store source value
//   mem_ready         1 only while IDLE; upstream stalls otherwise
//   data_*            bus: req/wr/size/addr/wdata out, addr_ok/data_ok/rdata in
//   mem_valid         one-cycle pulse per completed instruction
//   mem_wd/mem_reg    destination and write enable to WB (0 when not valid)
//   mem_wdata         write-back data (holds its value between pulses)
//   mem_excp          address-error flag, qualified by mem_valid
// -----------------------------------------------------------------------------
module mem (
  input  logic        clk,
  input  logic        rst,
  // EX side
  input  logic        ex_valid,
  input  logic [4:0]  ex_wd,
  input  logic        ex_reg,
  input  logic [31:0] ex_wdata,
  input  logic [3:0]  ex_memop,
  input  logic [31:0] ex_addr,
  input  logic [31:0] ex_sdata,
  output logic        mem_ready,
  // data bus
  output logic        data_req,
  output logic        data_wr,
  output logic [1:0]  data_size,
  output logic [31:0] data_addr,
  output logic [31:0] data_wdata,
  input  logic        data_addr_ok,
  input  logic        data_data_ok,
  input  logic [31:0] data_rdata,
  // WB side
  output logic        mem_valid,
  output logic [4:0]  mem_wd,
  output logic        mem_reg,
  output logic [31:0] mem_wdata,
  output logic        mem_excp
);

  localparam logic [3:0] OP_LB  = 4'd1;
  localparam logic [3:0] OP_LBU = 4'd2;
  localparam logic [3:0] OP_LH  = 4'd3;
  localparam logic [3:0] OP_LHU = 4'd4;
  localparam logic [3:0] OP_LW  = 4'd5;
  localparam logic [3:0] OP_SB  = 4'd6;
  localparam logic [3:0] OP_SH  = 4'd7;
  localparam logic [3:0] OP_SW  = 4'd8;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } state_t;

  // ---------------------------------------------------------------------------
  // Op decode helpers
  // ---------------------------------------------------------------------------
  function automatic logic op_is_mem(input logic [3:0] op);
    return (op >= OP_LB) && (op <= OP_SW);
  endfunction

  function automatic logic op_is_store(input logic [3:0] op);
    return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
  endfunction

  function automatic logic [1:0] op_size(input logic [3:0] op);
    logic [1:0] sz;
    case (op)
      OP_LH, OP_LHU, OP_SH: sz = SIZE_HALF;
      OP_LW, OP_SW:         sz = SIZE_WORD;
      default:              sz = SIZE_BYTE;
    endcase
    return sz;
  endfunction

  // ---------------------------------------------------------------------------
  // State and latched instruction
  // ---------------------------------------------------------------------------
  state_t      state_q, state_d;
  logic [4:0]  wd_q;
  logic        reg_q;
  logic [3:0]  op_q;
  logic [31:0] addr_q;
  logic [31:0] sdata_q;

  logic        transfer;
  logic        ex_is_mem;
  logic [1:0]  ex_size;
  logic        ex_misaligned;
  logic        complete;

  assign mem_ready = (state_q == ST_IDLE);
  assign transfer  = ex_valid & mem_ready;
  assign ex_is_mem = op_is_mem(ex_memop);
  assign ex_size   = op_size(ex_memop);

  always_comb begin
    ex_misaligned = 1'b0;
    if (ex_is_mem) begin
      case (ex_size)
        SIZE_HALF: ex_misaligned = ex_addr[0];
        SIZE_WORD: ex_misaligned = (ex_addr[1:0] != 2'b00);
        default:   ex_misaligned = 1'b0;
      endcase
    end
  end

  // A data_ok only counts once the address phase has been accepted, either in
  // WAIT or in the same cycle as addr_ok while in REQ.
  assign complete = ((state_q == ST_REQ) && data_addr_ok && data_data_ok) ||
                    ((state_q == ST_WAIT) && data_data_ok);

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (transfer && ex_is_mem && !ex_misaligned) begin
          state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        if (data_addr_ok) begin
          state_d = data_data_ok ? ST_IDLE : ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (data_data_ok) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Instruction latch: captured only when a memory op is accepted, so the bus
  // fields stay stable for the whole REQ/WAIT sequence.
  always_ff @(posedge clk) begin
    if (rst) begin
      wd_q    <= '0;
      reg_q   <= 1'b0;
      op_q    <= '0;
      addr_q  <= '0;
      sdata_q <= '0;
    end else if (transfer && ex_is_mem) begin
      wd_q    <= ex_wd;
      reg_q   <= ex_reg;
      op_q    <= ex_memop;
      addr_q  <= ex_addr;
      sdata_q <= ex_sdata;
    end
  end

  // ---------------------------------------------------------------------------
  // Bus outputs (output process of the FSM); all zero outside REQ
  // ---------------------------------------------------------------------------
  logic [31:0] store_lanes;

  always_comb begin
    case (op_q)
      OP_SB:   store_lanes = {4{sdata_q[7:0]}};
      OP_SH:   store_lanes = {2{sdata_q[15:0]}};
      default: store_lanes = sdata_q;
    endcase
  end

  always_comb begin
    data_req   = 1'b0;
    data_wr    = 1'b0;
    data_size  = 2'd0;
    data_addr  = '0;
    data_wdata = '0;
    if (state_q == ST_REQ) begin
      data_req   = 1'b1;
      data_wr    = op_is_store(op_q);
      data_size  = op_size(op_q);
      data_addr  = addr_q;
      data_wdata = op_is_store(op_q) ? store_lanes : 32'd0;
    end
  end

  // ---------------------------------------------------------------------------
  // Load alignment: little-endian byte lanes of the returned word
  // ---------------------------------------------------------------------------
  logic [7:0]  rdata_byte [4];
  logic [7:0]  load_byte;
  logic [15:0] load_half;
  logic [31:0] load_data;

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      assign rdata_byte[gi] = data_rdata[8*gi +: 8];
    end
  endgenerate

  assign load_byte = rdata_byte[addr_q[1:0]];
  assign load_half = addr_q[1] ? data_rdata[31:16] : data_rdata[15:0];

  always_comb begin
    case (op_q)
      OP_LB:   load_data = {{24{load_byte[7]}}, load_byte};
      OP_LBU:  load_data = {24'd0, load_byte};
      OP_LH:   load_data = {{16{load_half[15]}}, load_half};
      OP_LHU:  load_data = {16'd0, load_half};
      OP_LW:   load_data = data_rdata;
      default: load_data = 32'd0;
    endcase
  end

  // ---------------------------------------------------------------------------
  // MEM/WB result register
  // ---------------------------------------------------------------------------
  logic        mem_valid_q, mem_valid_d;
  logic [4:0]  mem_wd_q,    mem_wd_d;
  logic        mem_reg_q,   mem_reg_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic        mem_excp_q,  mem_excp_d;

  always_comb begin
    // Side-band fields drop to zero between pulses; the data field holds.
    mem_valid_d = 1'b0;
    mem_wd_d    = '0;
    mem_reg_d   = 1'b0;
    mem_excp_d  = 1'b0;
    mem_wdata_d = mem_wdata_q;
    if (transfer && !ex_is_mem) begin
      mem_valid_d = 1'b1;
      mem_wd_d    = ex_wd;
      mem_reg_d   = ex_reg;
      mem_wdata_d = ex_wdata;
    end else if (transfer && ex_misaligned) begin
      // Bad address is reported in the data field for the exception handler.
      mem_valid_d = 1'b1;
      mem_wd_d    = ex_wd;
      mem_excp_d  = 1'b1;
      mem_wdata_d = ex_addr;
    end else if (complete) begin
      mem_valid_d = 1'b1;
      mem_wd_d    = wd_q;
      mem_reg_d   = reg_q;
      mem_wdata_d = op_is_store(op_q) ? 32'd0 : load_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_valid_q <= 1'b0;
      mem_wd_q    <= '0;
      mem_reg_q   <= 1'b0;
      mem_wdata_q <= '0;
      mem_excp_q  <= 1'b0;
    end else begin
      mem_valid_q <= mem_valid_d;
      mem_wd_q    <= mem_wd_d;
      mem_reg_q   <= mem_reg_d;
      mem_wdata_q <= mem_wdata_d;
      mem_excp_q  <= mem_excp_d;
    end
  end

  assign mem_valid = mem_valid_q;
  assign mem_wd    = mem_wd_q;
  assign mem_reg   = mem_reg_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_excp  = mem_excp_q;

endmodule

// File: tb/tb_mem.sv
module tb_mem;

  logic        clk;
  logic        rst;
  logic        ex_valid;
  logic [4:0]  ex_wd;
  logic        ex_reg;
  logic [31:0] ex_wdata;
  logic [3:0]  ex_memop;
  logic [31:0] ex_addr;
  logic [31:0] ex_sdata;
  logic        mem_ready;
  logic        data_req;
  logic        data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic        data_addr_ok;
  logic        data_data_ok;
  logic [31:0] data_rdata;
  logic        mem_valid;
  logic [4:0]  mem_wd;
  logic        mem_reg;
  logic [31:0] mem_wdata;
  logic        mem_excp;

  int checks = 0;
  int failures = 0;

  mem dut (
    .clk          (clk),
    .rst          (rst),
    .ex_valid     (ex_valid),
    .ex_wd        (ex_wd),
    .ex_reg       (ex_reg),
    .ex_wdata     (ex_wdata),
    .ex_memop     (ex_memop),
    .ex_addr      (ex_addr),
    .ex_sdata     (ex_sdata),
    .mem_ready    (mem_ready),
    .data_req     (data_req),
    .data_wr      (data_wr),
    .data_size    (data_size),
    .data_addr    (data_addr),
    .data_wdata   (data_wdata),
    .data_addr_ok (data_addr_ok),
    .data_data_ok (data_data_ok),
    .data_rdata   (data_rdata),
    .mem_valid    (mem_valid),
    .mem_wd       (mem_wd),
    .mem_reg      (mem_reg),
    .mem_wdata    (mem_wdata),
    .mem_excp     (mem_excp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  // Advance to the start of the next cycle; inputs change here, outputs are
  // sampled a further #1 later, well clear of the clock edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    ex_valid     = 1'b0;
    ex_wd        = '0;
    ex_reg       = 1'b0;
    ex_wdata     = '0;
    ex_memop     = '0;
    ex_addr      = '0;
    ex_sdata     = '0;
    data_addr_ok = 1'b0;
    data_data_ok = 1'b0;
    data_rdata   = '0;
  endtask

  task automatic present(input logic [3:0] op, input logic [4:0] wd, input logic rg,
                         input logic [31:0] wdata, input logic [31:0] addr,
                         input logic [31:0] sdata);
    ex_valid = 1'b1;
    ex_memop = op;
    ex_wd    = wd;
    ex_reg   = rg;
    ex_wdata = wdata;
    ex_addr  = addr;
    ex_sdata = sdata;
  endtask

  // Aligned load with addr_ok and data_ok in the request cycle.
  task automatic quick_load(input string name, input logic [3:0] op, input logic [31:0] addr,
                            input logic [31:0] rdata, input logic [1:0] size,
                            input logic [31:0] exp);
    present(op, 5'd9, 1'b1, 32'd0, addr, 32'd0);
    tick();
    clear_inputs();
    data_addr_ok = 1'b1;
    data_data_ok = 1'b1;
    data_rdata   = rdata;
    #1;
    check({name, "_req"}, {31'd0, data_req}, 32'd1);
    check({name, "_size"}, {30'd0, data_size}, {30'd0, size});
    check({name, "_addr"}, data_addr, addr);
    tick();
    clear_inputs();
    #1;
    check({name, "_valid"}, {31'd0, mem_valid}, 32'd1);
    check({name, "_data"}, mem_wdata, exp);
    $display("txn %s addr=0x%08h rdata=0x%08h wb=0x%08h", name, addr, rdata, mem_wdata);
  endtask

  initial begin
    int ready_low;
    int pulses;

    clear_inputs();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    #1;
    check("rst_ready", {31'd0, mem_ready}, 32'd1);
    check("rst_req", {31'd0, data_req}, 32'd0);
    check("rst_addr", data_addr, 32'd0);
    check("rst_valid", {31'd0, mem_valid}, 32'd0);
    check("rst_wdata", mem_wdata, 32'd0);
    check("rst_excp", {31'd0, mem_excp}, 32'd0);
    $display("txn reset");

    // Back-to-back ALU ops.
    tick();
    present(4'd0, 5'd3, 1'b1, 32'h11, 32'h0, 32'h0);
    #1;
    check("alu0_ready", {31'd0, mem_ready}, 32'd1);
    tick();
    present(4'd0, 5'd4, 1'b1, 32'h22, 32'h0, 32'h0);
    #1;
    check("alu0_valid", {31'd0, mem_valid}, 32'd1);
    check("alu0_wd", {27'd0, mem_wd}, 32'd3);
    check("alu0_wdata", mem_wdata, 32'h11);
    check("alu1_ready", {31'd0, mem_ready}, 32'd1);
    tick();
    clear_inputs();
    #1;
    check("alu1_valid", {31'd0, mem_valid}, 32'd1);
    check("alu1_wd", {27'd0, mem_wd}, 32'd4);
    check("alu1_reg", {31'd0, mem_reg}, 32'd1);
    check("alu1_wdata", mem_wdata, 32'h22);
    tick();
    #1;
    check("alu_idle_valid", {31'd0, mem_valid}, 32'd0);
    check("alu_idle_wd", {27'd0, mem_wd}, 32'd0);
    check("alu_idle_reg", {31'd0, mem_reg}, 32'd0);
    check("alu_hold_wdata", mem_wdata, 32'h22);
    $display("txn alu back-to-back");

    // Memop code 9 behaves as a plain ALU op.
    present(4'd9, 5'd2, 1'b1, 32'hCAFE_0009, 32'h1, 32'h0);
    #1;
    check("op9_noreq", {31'd0, data_req}, 32'd0);
    tick();
    clear_inputs();
    #1;
    check("op9_valid", {31'd0, mem_valid}, 32'd1);
    check("op9_wdata", mem_wdata, 32'hCAFE_0009);
    check("op9_ready", {31'd0, mem_ready}, 32'd1);
    $display("txn op9 passthrough");

    // Aligned loads, single-cycle bus.
    quick_load("lb", 4'd1, 32'h0000_1003, 32'h80FF_1234, 2'd0, 32'hFFFF_FF80);
    check("lb_ready", {31'd0, mem_ready}, 32'd1);
    quick_load("lbu", 4'd2, 32'h0000_0001, 32'h0000_9A00, 2'd0, 32'h0000_009A);
    quick_load("lh", 4'd3, 32'h0000_4000, 32'h1234_8001, 2'd1, 32'hFFFF_8001);
    quick_load("lw", 4'd5, 32'h0000_0010, 32'hDEAD_BEEF, 2'd2, 32'hDEAD_BEEF);

    // LHU with 2 addr_ok wait states then 3 more cycles to data_ok. A stray
    // data_ok in REQ before addr_ok must be ignored.
    present(4'd4, 5'd6, 1'b1, 32'd0, 32'h0000_2002, 32'd0);
    tick();
    clear_inputs();
    ready_low = 0;
    pulses = 0;
    for (int c = 1; c <= 6; c++) begin
      data_addr_ok = (c == 3);
      data_data_ok = (c == 2) || (c == 6);
      data_rdata   = 32'hBEEF_0000;
      #1;
      if (!mem_ready) ready_low++;
      if (mem_valid) pulses++;
      if (c == 3) check("lhu_size", {30'd0, data_size}, 32'd1);
      if (c == 4) check("lhu_wait_noreq", {31'd0, data_req}, 32'd0);
      if (c == 4) check("lhu_wait_addr", data_addr, 32'd0);
      tick();
    end
    clear_inputs();
    #1;
    check("lhu_ready_low", ready_low, 32'd6);
    check("lhu_early_pulses", pulses, 32'd0);
    check("lhu_valid", {31'd0, mem_valid}, 32'd1);
    check("lhu_wd", {27'd0, mem_wd}, 32'd6);
    check("lhu_data", mem_wdata, 32'h0000_BEEF);
    $display("txn lhu slow bus ready_low=%0d", ready_low);

    // SB with addr_ok then data_ok one cycle later.
    present(4'd6, 5'd0, 1'b0, 32'd0, 32'h0, 32'h1234_56AB);
    tick();
    clear_inputs();
    data_addr_ok = 1'b1;
    #1;
    check("sb_wr", {31'd0, data_wr}, 32'd1);
    check("sb_wdata", data_wdata, 32'hABAB_ABAB);
    check("sb_size", {30'd0, data_size}, 32'd0);
    tick();
    clear_inputs();
    data_data_ok = 1'b1;
    #1;
    check("sb_wait_wr", {31'd0, data_wr}, 32'd0);
    check("sb_wait_wdata", data_wdata, 32'd0);
    tick();
    clear_inputs();
    #1;
    check("sb_valid", {31'd0, mem_valid}, 32'd1);
    check("sb_reg", {31'd0, mem_reg}, 32'd0);
    check("sb_data", mem_wdata, 32'd0);
    $display("txn sb");

    // SH lane replication.
    present(4'd7, 5'd0, 1'b0, 32'd0, 32'h0000_0012, 32'h1234_5678);
    tick();
    clear_inputs();
    data_addr_ok = 1'b1;
    data_data_ok = 1'b1;
    #1;
    check("sh_wdata", data_wdata, 32'h5678_5678);
    check("sh_size", {30'd0, data_size}, 32'd1);
    tick();
    clear_inputs();
    #1;
    check("sh_valid", {31'd0, mem_valid}, 32'd1);
    $display("txn sh");

    // Misaligned LW: no bus request, exception one cycle later.
    present(4'd5, 5'd7, 1'b1, 32'd0, 32'h0000_0006, 32'd0);
    #1;
    check("lwx_ready", {31'd0, mem_ready}, 32'd1);
    tick();
    clear_inputs();
    #1;
    check("lwx_noreq", {31'd0, data_req}, 32'd0);
    check("lwx_valid", {31'd0, mem_valid}, 32'd1);
    check("lwx_excp", {31'd0, mem_excp}, 32'd1);
    check("lwx_reg", {31'd0, mem_reg}, 32'd0);
    check("lwx_data", mem_wdata, 32'h0000_0006);
    tick();
    #1;
    check("lwx_after_valid", {31'd0, mem_valid}, 32'd0);
    check("lwx_after_excp", {31'd0, mem_excp}, 32'd0);
    $display("txn lw misaligned");

    // Misaligned LH at odd address.
    present(4'd3, 5'd7, 1'b1, 32'd0, 32'h0000_0101, 32'd0);
    tick();
    clear_inputs();
    #1;
    check("lhx_noreq", {31'd0, data_req}, 32'd0);
    check("lhx_excp", {31'd0, mem_excp}, 32'd1);
    check("lhx_data", mem_wdata, 32'h0000_0101);
    tick();
    $display("txn lh misaligned");

    // Reset while in WAIT, then a late data_ok.
    present(4'd5, 5'd8, 1'b1, 32'd0, 32'h0000_0100, 32'd0);
    tick();
    clear_inputs();
    data_addr_ok = 1'b1;
    tick();
    clear_inputs();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    data_data_ok = 1'b1;
    data_rdata   = 32'h5555_AAAA;
    #1;
    check("rstw_ready", {31'd0, mem_ready}, 32'd1);
    check("rstw_req", {31'd0, data_req}, 32'd0);
    check("rstw_valid", {31'd0, mem_valid}, 32'd0);
    check("rstw_wdata", mem_wdata, 32'd0);
    pulses = 0;
    for (int c = 0; c < 3; c++) begin
      tick();
      clear_inputs();
      #1;
      if (mem_valid) pulses++;
    end
    check("rstw_pulses", pulses, 32'd0);
    check("rstw_wdata_after", mem_wdata, 32'd0);
    check("rstw_ready_after", {31'd0, mem_ready}, 32'd1);
    $display("txn reset in wait");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
